// File: rtl/vc_test_rand_delay_mem_resp_pkg.sv
// Shared definitions for the random-delay memory response buffer:
// FSM state encodings, LFSR tap mask, default seed and the LFSR step function.
package vc_test_rand_delay_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SEND  = 2'd2
    } state_e;

    // Galois tap mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/vc_test_lfsr16.sv
// 16-bit Galois LFSR that advances one step per cycle while en is high.
// The register loads p_seed during the asynchronous active-low reset.
module vc_test_lfsr16
    import vc_test_rand_delay_mem_resp_pkg::*;
#(
    parameter logic [15:0] p_seed = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = en ? lfsr_step(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= p_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/vc_test_rand_delay_mem_resp.sv
// Single-entry buffer that holds each memory response for 0..p_max_delay extra cycles.
// Define VC_TEST_RAND_DELAY_STATS_EN to add the msg_count/stall_count outputs.
module vc_test_rand_delay_mem_resp
    import vc_test_rand_delay_mem_resp_pkg::*;
#(
    parameter int          p_msg_sz    = 37,
    parameter int          p_max_delay = 7,
    parameter logic [15:0] p_seed      = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [p_msg_sz-1:0] in_msg,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [p_msg_sz-1:0] out_msg
`ifdef VC_TEST_RAND_DELAY_STATS_EN
    ,
    output logic [31:0]         msg_count,
    output logic [31:0]         stall_count
`endif
);

    localparam int          CW  = (p_max_delay < 1) ? 1 : $clog2(p_max_delay + 1);
    localparam logic [15:0] MOD = 16'(p_max_delay + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [p_msg_sz-1:0]   msg_q, msg_d;
    logic [15:0]           lfsr_val;
    logic [CW-1:0]         delay_draw;
    logic                  accept;

    assign accept     = in_val && in_rdy;
    assign delay_draw = CW'(lfsr_val % MOD);

    vc_test_lfsr16 #(
        .p_seed (p_seed)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .out   (lfsr_val)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        msg_d   = msg_q;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
            end
            DELAY: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                out_val = 1'b1;
                in_rdy  = out_rdy;
                if (out_rdy && !in_val) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new message is loaded from IDLE or on a same-cycle dequeue in SEND
        if (accept) begin
            msg_d = in_msg;
            if (delay_draw == '0) begin
                state_d = SEND;
            end else begin
                count_d = delay_draw;
                state_d = DELAY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            msg_q   <= msg_d;
        end
    end

    assign out_msg = msg_q;

`ifdef VC_TEST_RAND_DELAY_STATS_EN
    logic [31:0] msg_count_q, stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (out_val && out_rdy) begin
                msg_count_q <= msg_count_q + 32'd1;
            end
            if (out_val && !out_rdy) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign msg_count   = msg_count_q;
    assign stall_count = stall_count_q;
`endif

`ifndef SYNTHESIS
    a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({in_val, out_rdy}));
`endif

endmodule
